// File: rtl/arb_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package arb_pkg;

    localparam int NUM_REQ          = 4;
    localparam int ID_W             = 2;
    localparam int DEFAULT_MAX_HOLD = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    typedef logic [NUM_REQ-1:0] req_vec_t;
    typedef logic [ID_W-1:0]    req_id_t;

    function automatic req_vec_t id_to_onehot(input req_id_t id);
        return req_vec_t'(1) << id;
    endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the requesting units and the arbiter.
interface rr_arbiter_4_if;
    import arb_pkg::*;

    req_vec_t req;
    req_vec_t gnt;
    req_id_t  gnt_id;
    logic     gnt_valid;
    logic     preempt;

    modport master (output req, input gnt, gnt_id, gnt_valid, preempt);
    modport slave  (input req, output gnt, gnt_id, gnt_valid, preempt);

endinterface

// File: rtl/rr_arbiter_4_pick4.sv
// Combinational round-robin selector: first set request at or after ptr, mod 4.
module rr_pick4
    import arb_pkg::*;
(
    input  req_vec_t req,
    input  req_id_t  ptr,
    output logic     any,
    output req_id_t  pick_id
);

    logic [2*NUM_REQ-1:0] req_dbl;
    req_vec_t             rot;
    req_id_t              enc;

    // NOTE: combinational blocks use blocking assignments and give every output a
    // default first, so later statements see updated values and no latch is inferred.
    always_comb begin
        req_dbl = {req, req};
        rot     = req_dbl[ptr +: NUM_REQ];
        enc     = '0;
        // Scanning downward leaves the lowest set index in enc.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) enc = req_id_t'(i);
        end
        any     = |req;
        pick_id = enc + ptr;
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot/encoded grant
// and a hold limit that forces release while others are waiting.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic           clk,
    input  logic           rst,
    rr_arbiter_4_if.slave  bus
);

    localparam int                HCNT_W    = $clog2(MAX_HOLD + 1);
    localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(MAX_HOLD - 1);

    arb_state_e        state_q, state_d;
    req_id_t           ptr_q, ptr_d;
    req_id_t           owner_q, owner_d;
    req_vec_t          gnt_q, gnt_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic              preempt_q, preempt_d;

    logic    pick_any;
    req_id_t pick_id;
    logic    owner_req;
    logic    others_req;

    rr_pick4 u_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .any     (pick_any),
        .pick_id (pick_id)
    );

    // gnt_q is one-hot on the owner while granted, so it doubles as the owner mask.
    assign owner_req  = |(bus.req & gnt_q);
    assign others_req = |(bus.req & ~gnt_q);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        gnt_d     = gnt_q;
        hcnt_d    = hcnt_q;
        preempt_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    owner_d = pick_id;
                    gnt_d   = id_to_onehot(pick_id);
                    ptr_d   = pick_id + req_id_t'(1);
                    hcnt_d  = '0;
                end
            end

            GRANT: begin
                if (!owner_req || (hcnt_q == HOLD_LAST && others_req)) begin
                    state_d   = IDLE;
                    owner_d   = '0;
                    gnt_d     = '0;
                    hcnt_d    = '0;
                    preempt_d = owner_req;
                end else if (hcnt_q == HOLD_LAST) begin
                    // Nobody else is waiting: renew the hold window instead of releasing.
                    hcnt_d = '0;
                end else begin
                    hcnt_d = hcnt_q + HCNT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            gnt_q     <= '0;
            hcnt_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            gnt_q     <= gnt_d;
            hcnt_q    <= hcnt_d;
            preempt_q <= preempt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = owner_q;
    assign bus.gnt_valid = (state_q == GRANT);
    assign bus.preempt   = preempt_q;

endmodule
